page_multi_qin: RTL and testbench



---
 rtl/page_q_pkg.sv | 27 ++
 rtl/page_qin_chan.sv | 96 +++++++++
 rtl/page_multi_qin.sv | 64 ++++++
 tb/tb_page_multi_qin.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/page_q_pkg.sv
// page_q_pkg: shared definitions for the page input queues.
//   - clog2: ceiling log2 usable in parameter expressions.
//   - Token packing: a stored token is {data, eos}; EOS sits in the LSB.
//   - Parameter legality macros used by the queue modules at elaboration.
`ifndef PAGE_Q_PKG_SV
`define PAGE_Q_PKG_SV

`define PAGE_Q_IS_POW2(x) (((x) >= 2) && (((x) & ((x) - 1)) == 0))
`define PAGE_Q_SLACK_OK(s, d) (((s) >= 0) && ((s) < (d)))

package page_q_pkg;

  localparam int TOK_EOS_BIT  = 0;
  localparam int TOK_DATA_LSB = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/page_qin_chan.sv
// page_qin_chan: one channel of the page input queue.
// A DEPTH-entry circular FIFO of {data, eos} tokens with registered occupancy,
// back-pressure that leaves SLACK entries of headroom, a sticky end-of-stream
// flag and a sticky overflow flag.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   in_d, in_e, in_v, in_b  : producer side (data, eos, valid, back-pressure)
//   out_d, out_e, out_v, out_b : consumer side (head data, eos, valid, stall)
//   count                   : current occupancy
//   eos_seen                : set when an eos token is dequeued
//   ovf                     : set when a token arrives with no room for it
module page_qin_chan
  import page_q_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int SLACK = 0,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [W-1:0]  in_d,
  input  logic          in_e,
  input  logic          in_v,
  output logic          in_b,
  output logic [W-1:0]  out_d,
  output logic          out_e,
  output logic          out_v,
  input  logic          out_b,
  output logic [CW-1:0] count,
  output logic          eos_seen,
  output logic          ovf
);

  localparam int AW = clog2(DEPTH);
  localparam int TW = W + 1;

  if (!`PAGE_Q_IS_POW2(DEPTH)) begin : g_bad_depth
    $error("page_qin_chan: DEPTH must be a power of two >= 2");
  end
  if (!`PAGE_Q_SLACK_OK(SLACK, DEPTH)) begin : g_bad_slack
    $error("page_qin_chan: SLACK must satisfy 0 <= SLACK < DEPTH");
  end

  logic [TW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [TW-1:0] tok_in;
  logic [TW-1:0] head;
  logic          full;
  logic          deq;
  logic          enq;
  logic          drop;

  assign tok_in[TOK_EOS_BIT]      = in_e;
  assign tok_in[TOK_DATA_LSB +: W] = in_d;

  assign head  = mem[rptr];
  assign out_v = (count != '0);
  assign out_d = head[TOK_DATA_LSB +: W];
  assign out_e = head[TOK_EOS_BIT];

  assign full = (count == CW'(DEPTH));
  assign deq  = out_v & ~out_b;
  // A full queue still accepts when the head leaves on the same edge; the
  // write lands in the slot being vacated (wptr == rptr when full).
  assign enq  = in_v & ~(full & ~deq) & ~reset;
  assign drop = in_v & full & ~deq;

  assign in_b = reset | (count >= CW'(DEPTH - SLACK));

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (enq) mem[wptr] <= tok_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      eos_seen <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (enq) wptr <= wptr + AW'(1);
      if (deq) begin
        rptr <= rptr + AW'(1);
        if (out_e) eos_seen <= 1'b1;
      end
      if (drop) ovf <= 1'b1;
      if (enq & ~deq)      count <= count + CW'(1);
      else if (deq & ~enq) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/page_multi_qin.sv
// page_multi_qin: NCH independent page input queues.
// Slices the packed channel buses and instantiates one page_qin_chan per
// channel; there is no interaction between channels.
// Ports (channel c occupies slice c of each bus):
//   clock, reset               : clock, synchronous active-high reset
//   qin_d [NCH*W], qin_e, qin_v, qin_b   : producer side
//   qout_d [NCH*W], qout_e, qout_v, qout_b : consumer side
//   count [NCH*CW]             : per-channel occupancy
//   eos_seen, ovf              : per-channel sticky flags
module page_multi_qin
  import page_q_pkg::*;
#(
  parameter int NCH   = 1,
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int SLACK = 0,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH*W-1:0]  qin_d,
  input  logic [NCH-1:0]    qin_e,
  input  logic [NCH-1:0]    qin_v,
  output logic [NCH-1:0]    qin_b,
  output logic [NCH*W-1:0]  qout_d,
  output logic [NCH-1:0]    qout_e,
  output logic [NCH-1:0]    qout_v,
  input  logic [NCH-1:0]    qout_b,
  output logic [NCH*CW-1:0] count,
  output logic [NCH-1:0]    eos_seen,
  output logic [NCH-1:0]    ovf
);

  if (!`PAGE_Q_IS_POW2(DEPTH)) begin : g_bad_depth
    $error("page_multi_qin: DEPTH must be a power of two >= 2");
  end
  if (!`PAGE_Q_SLACK_OK(SLACK, DEPTH)) begin : g_bad_slack
    $error("page_multi_qin: SLACK must satisfy 0 <= SLACK < DEPTH");
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    page_qin_chan #(
      .W     (W),
      .DEPTH (DEPTH),
      .SLACK (SLACK),
      .CW    (CW)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .in_d     (qin_d[c*W +: W]),
      .in_e     (qin_e[c]),
      .in_v     (qin_v[c]),
      .in_b     (qin_b[c]),
      .out_d    (qout_d[c*W +: W]),
      .out_e    (qout_e[c]),
      .out_v    (qout_v[c]),
      .out_b    (qout_b[c]),
      .count    (count[c*CW +: CW]),
      .eos_seen (eos_seen[c]),
      .ovf      (ovf[c])
    );
  end

endmodule

// File: tb/tb_page_multi_qin.sv
// tb_page_multi_qin: bench for page_multi_qin.
// Two instances: A (NCH=2, DEPTH=4, SLACK=0) and B (NCH=2, DEPTH=8, SLACK=1).
// A queue-based reference model tracks every channel and is compared with
// the DUT outputs after each clock edge; directed sequences add explicit
// expectations for the interesting corners, followed by a random soak.
module tb_page_multi_qin;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [31:0] a_qin_d, a_qout_d, b_qin_d, b_qout_d;
  logic [1:0]  a_qin_e, a_qin_v, a_qin_b, a_qout_e, a_qout_v, a_qout_b, a_eos, a_ovf;
  logic [1:0]  b_qin_e, b_qin_v, b_qin_b, b_qout_e, b_qout_v, b_qout_b, b_eos, b_ovf;
  logic [5:0]  a_count;
  logic [7:0]  b_count;

  logic [15:0] drv_d [2][2];
  logic        drv_e [2][2];
  logic        drv_v [2][2];
  logic        drv_b [2][2];

  assign a_qin_d  = {drv_d[0][1], drv_d[0][0]};
  assign a_qin_e  = {drv_e[0][1], drv_e[0][0]};
  assign a_qin_v  = {drv_v[0][1], drv_v[0][0]};
  assign a_qout_b = {drv_b[0][1], drv_b[0][0]};
  assign b_qin_d  = {drv_d[1][1], drv_d[1][0]};
  assign b_qin_e  = {drv_e[1][1], drv_e[1][0]};
  assign b_qin_v  = {drv_v[1][1], drv_v[1][0]};
  assign b_qout_b = {drv_b[1][1], drv_b[1][0]};

  page_multi_qin #(.NCH(2), .W(16), .DEPTH(4), .SLACK(0)) u_dut_a (
    .clock(clock), .reset(reset),
    .qin_d(a_qin_d), .qin_e(a_qin_e), .qin_v(a_qin_v), .qin_b(a_qin_b),
    .qout_d(a_qout_d), .qout_e(a_qout_e), .qout_v(a_qout_v), .qout_b(a_qout_b),
    .count(a_count), .eos_seen(a_eos), .ovf(a_ovf)
  );

  page_multi_qin #(.NCH(2), .W(16), .DEPTH(8), .SLACK(1)) u_dut_b (
    .clock(clock), .reset(reset),
    .qin_d(b_qin_d), .qin_e(b_qin_e), .qin_v(b_qin_v), .qin_b(b_qin_b),
    .qout_d(b_qout_d), .qout_e(b_qout_e), .qout_v(b_qout_v), .qout_b(b_qout_b),
    .count(b_count), .eos_seen(b_eos), .ovf(b_ovf)
  );

  // Reference model: one token queue per channel plus the two sticky flags.
  logic [16:0] mq [2][2][$];
  bit          m_eos [2][2];
  bit          m_ovf [2][2];
  int          m_deq [2][2];
  int          depth_of [2] = '{4, 8};
  int          slack_of [2] = '{0, 1};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_chan(input int d, input int c, input logic [15:0] od,
                            input logic oe, input logic ov, input logic ob,
                            input logic [3:0] cnt, input logic eos, input logic ovf);
    int    sz;
    string p;
    sz = mq[d][c].size();
    p  = $sformatf("m%0d_ch%0d", d, c);
    check_val({p, "_count"}, 32'(cnt), 32'(sz));
    check_val({p, "_qin_b"}, 32'(ob), 32'(reset || (sz >= depth_of[d] - slack_of[d])));
    check_val({p, "_qout_v"}, 32'(ov), 32'(sz != 0));
    if (sz != 0) begin
      check_val({p, "_qout_d"}, 32'(od), 32'(mq[d][c][0][16:1]));
      check_val({p, "_qout_e"}, 32'(oe), 32'(mq[d][c][0][0]));
    end
    check_val({p, "_eos_seen"}, 32'(eos), 32'(m_eos[d][c]));
    check_val({p, "_ovf"}, 32'(ovf), 32'(m_ovf[d][c]));
  endtask

  task automatic check_all();
    check_chan(0, 0, a_qout_d[15:0],  a_qout_e[0], a_qout_v[0], a_qin_b[0], {1'b0, a_count[2:0]}, a_eos[0], a_ovf[0]);
    check_chan(0, 1, a_qout_d[31:16], a_qout_e[1], a_qout_v[1], a_qin_b[1], {1'b0, a_count[5:3]}, a_eos[1], a_ovf[1]);
    check_chan(1, 0, b_qout_d[15:0],  b_qout_e[0], b_qout_v[0], b_qin_b[0], b_count[3:0], b_eos[0], b_ovf[0]);
    check_chan(1, 1, b_qout_d[31:16], b_qout_e[1], b_qout_v[1], b_qin_b[1], b_count[7:4], b_eos[1], b_ovf[1]);
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        int sz;
        bit deq;
        if (reset) begin
          mq[d][c].delete();
          m_eos[d][c] = 1'b0;
          m_ovf[d][c] = 1'b0;
        end else begin
          sz  = mq[d][c].size();
          deq = (sz != 0) && !drv_b[d][c];
          if (deq) begin
            if (mq[d][c][0][0]) m_eos[d][c] = 1'b1;
            void'(mq[d][c].pop_front());
            m_deq[d][c]++;
          end
          if (drv_v[d][c]) begin
            if (sz < depth_of[d] || deq) mq[d][c].push_back({drv_d[d][c], drv_e[d][c]});
            else m_ovf[d][c] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  task automatic drive(input int d, input int c, input logic v, input logic [15:0] data,
                       input logic e, input logic b);
    drv_v[d][c] = v;
    drv_d[d][c] = data;
    drv_e[d][c] = e;
    drv_b[d][c] = b;
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++)
        drive(d, c, 1'b0, 16'($urandom), 1'($urandom), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    int total;
    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_val("reset_count_a", 32'(a_count), 32'd0);
    check_val("reset_qout_v_a", 32'(a_qout_v), 32'd0);

    // In-order fill and drain, SLACK=0.
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 1'b1, 16'(17 * k), 1'b0, 1'b1);
      tick();
    end
    check_val("fill_count4", 32'(a_count[2:0]), 32'd4);
    check_val("fill_qin_b", 32'(a_qin_b[0]), 32'd1);
    drive(0, 0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      check_val("drain_order", 32'(a_qout_d[15:0]), 32'(17 * k));
      tick();
    end
    check_val("drain_empty", 32'(a_qout_v[0]), 32'd0);

    // Full with simultaneous dequeue and enqueue.
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 1'b1, 16'(k), 1'b0, 1'b1);
      tick();
    end
    drive(0, 0, 1'b1, 16'h00AA, 1'b0, 1'b0);
    tick();
    check_val("pass_count", 32'(a_count[2:0]), 32'd4);
    check_val("pass_ovf", 32'(a_ovf[0]), 32'd0);
    drive(0, 0, 1'b0, 16'h0, 1'b0, 1'b0);
    tick(); tick(); tick();
    check_val("pass_tail", 32'(a_qout_d[15:0]), 32'h00AA);
    tick();

    // Overflow with SLACK=0.
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 1'b1, 16'(k + 32), 1'b0, 1'b1);
      tick();
    end
    check_val("ovf0_flag", 32'(a_ovf[0]), 32'd1);
    check_val("ovf0_count", 32'(a_count[2:0]), 32'd4);

    // Slack headroom on B (DEPTH=8, SLACK=1).
    guard = 0;
    while (b_qin_b[0] == 1'b0 && guard < 20) begin
      drive(1, 0, 1'b1, 16'(guard + 16'h0100), 1'b0, 1'b1);
      tick();
      guard++;
    end
    check_val("slack_guard", 32'(guard < 20), 32'd1);
    check_val("slack_count7", 32'(b_count[3:0]), 32'd7);
    drive(1, 0, 1'b1, 16'h0200, 1'b0, 1'b1);
    tick();
    check_val("slack_count8", 32'(b_count[3:0]), 32'd8);
    check_val("slack_no_ovf", 32'(b_ovf[0]), 32'd0);
    drive(1, 0, 1'b1, 16'h0300, 1'b0, 1'b1);
    tick();
    check_val("slack_ovf", 32'(b_ovf[0]), 32'd1);
    check_val("slack_hold8", 32'(b_count[3:0]), 32'd8);
    drive(1, 0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) tick();

    // EOS marker on A channel 1.
    drive(0, 1, 1'b1, 16'h1234, 1'b1, 1'b1);
    tick();
    drive(0, 1, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    check_val("eos_queued", 32'(a_eos[1]), 32'd0);
    drive(0, 1, 1'b0, 16'h0, 1'b0, 1'b0);
    check_val("eos_head_e", 32'(a_qout_e[1]), 32'd1);
    tick();
    check_val("eos_set", 32'(a_eos[1]), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1'b1, 16'(k + 16'h0055), 1'b0, 1'b0);
      tick();
    end
    check_val("eos_sticky", 32'(a_eos[1]), 32'd1);
    drive(0, 1, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();

    // Independent channels: ch0 stalled, ch1 streaming.
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, ~a_qin_b[0], 16'($urandom), 1'b0, 1'b1);
      drive(0, 1, 1'b1, 16'(k + 100), 1'b0, 1'b0);
      tick();
      check_val("stream_ch1_count", 32'(a_count[5:3]), 32'd1);
      check_val("stream_ch1_v", 32'(a_qout_v[1]), 32'd1);
    end
    check_val("stream_deq_ch1", 32'(m_deq[0][1] >= 11), 32'd1);
    check_val("stall_ch0_count", 32'(a_count[2:0]), 32'd4);
    check_val("stall_qin_b", 32'(a_qin_b), 32'b01);
    check_val("stall_ch0_ovf", 32'(a_ovf[0]), 32'd0);

    // Reset in the middle of activity: count=3, ovf=1 on ch0.
    drive(0, 1, 1'b0, 16'h0, 1'b0, 1'b1);
    drive(0, 0, 1'b1, 16'h0777, 1'b0, 1'b1);
    tick();
    drive(0, 0, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    drive(0, 0, 1'b0, 16'h0, 1'b0, 1'b1);
    check_val("pre_rst_count", 32'(a_count[2:0]), 32'd3);
    check_val("pre_rst_ovf", 32'(a_ovf[0]), 32'd1);
    reset = 1'b1;
    drive(0, 0, 1'b1, 16'h0888, 1'b0, 1'b1);
    #1;
    check_val("rst_qin_b_comb", 32'(a_qin_b), 32'b11);
    @(negedge clock);
    tick();
    check_val("rst_count", 32'(a_count[2:0]), 32'd0);
    check_val("rst_qout_v", 32'(a_qout_v), 32'd0);
    check_val("rst_ovf", 32'(a_ovf), 32'd0);
    check_val("rst_eos", 32'(a_eos), 32'd0);
    tick();
    check_val("rst_enq_ignored", 32'(a_count[2:0]), 32'd0);
    reset = 1'b0;
    clear_inputs();
    tick();

    // Random soak on all channels of both instances.
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) m_deq[d][c] = 0;
    for (int n = 0; n < 16000; n++) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 2; c++) begin
          logic bp;
          logic v;
          bp = (d == 0) ? a_qin_b[c] : b_qin_b[c];
          v  = bp ? ($urandom_range(0, 99) < 10) : ($urandom_range(0, 99) < 75);
          drive(d, c, v, 16'($urandom), ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 20));
        end
      end
      tick();
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) drive(d, c, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    total = m_deq[1][0] + m_deq[1][1];
    check_val("soak_tokens_b", 32'(total >= 10000), 32'd1);
    check_val("soak_empty_b", 32'(b_qout_v), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
